// File: rtl/uriscv_muldiv_arb.sv
// rtl/uriscv_muldiv_arb.sv - two-port round-robin arbiter/sequencer for a shared muldiv unit (optional watchdog: UMD_ARB_TIMEOUT_EN)
module uriscv_muldiv_arb #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_ra_i,
    input  logic [31:0] req0_rb_i,
    output logic        req0_accept_o,
    output logic        resp0_valid_o,
    output logic [31:0] resp0_data_o,
    output logic        resp0_err_o,
    input  logic        flush0_i,

    input  logic        req1_valid_i,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_ra_i,
    input  logic [31:0] req1_rb_i,
    output logic        req1_accept_o,
    output logic        resp1_valid_o,
    output logic [31:0] resp1_data_o,
    output logic        resp1_err_o,

    output logic        md_valid_o,
    output logic [7:0]  md_inst_o,
    output logic [31:0] md_ra_o,
    output logic [31:0] md_rb_o,
    input  logic        md_stall_i,
    input  logic        md_ready_i,
    input  logic [31:0] md_result_i,

    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic        resp0_valid_q, resp0_valid_d;
    logic        resp1_valid_q, resp1_valid_d;
    logic        resp0_err_q, resp0_err_d;
    logic        resp1_err_q, resp1_err_d;
    logic [31:0] resp0_data_q, resp0_data_d;
    logic [31:0] resp1_data_q, resp1_data_d;

    logic        winner;
    logic        issue;
    logic [2:0]  sel_op;
    logic        timeout;

    // Arbitration: a lone requester wins, a tie goes to rr_ptr; nothing is offered while reset is held
    always_comb begin
        winner     = (req0_valid_i && req1_valid_i) ? rr_ptr_q : req1_valid_i;
        sel_op     = winner ? req1_op_i : req0_op_i;
        md_ra_o    = winner ? req1_ra_i : req0_ra_i;
        md_rb_o    = winner ? req1_rb_i : req0_rb_i;
        md_valid_o = (state_q == ST_IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
        md_inst_o  = 8'd0;
        if (md_valid_o) begin
            md_inst_o[sel_op] = 1'b1;
        end
        issue         = md_valid_o && !md_stall_i;
        req0_accept_o = issue && !winner;
        req1_accept_o = issue && winner;
    end

`ifdef UMD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reads k-1 in cycle k after issue; firing at TIMEOUT_CYCLES-2 puts the error pulse at cycle TIMEOUT_CYCLES
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    // Watchdog counter: cleared on issue, counts (saturating) while an operation is outstanding
    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = '0;
        end else if (state_q != ST_IDLE && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout = (state_q != ST_IDLE) && (cnt_q >= TO_LAST);
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 36);
    assign timeout = 1'b0;
`endif

    // Sequencer: issue, wait for the unit, route or discard its result
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp0_err_d   = 1'b0;
        resp1_err_d   = 1'b0;
        resp0_data_d  = resp0_data_q;
        resp1_data_d  = resp1_data_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    owner_d  = winner;
                    rr_ptr_d = !winner;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush0_i && !owner_q) begin
                    // A flush coinciding with the result simply drops it
                    state_d = md_ready_i ? ST_IDLE : ST_DRAIN;
                end else if (md_ready_i) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        resp1_valid_d = 1'b1;
                        resp1_data_d  = md_result_i;
                    end else begin
                        resp0_valid_d = 1'b1;
                        resp0_data_d  = md_result_i;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        resp1_valid_d = 1'b1;
                        resp1_err_d   = 1'b1;
                        resp1_data_d  = 32'd0;
                    end else begin
                        resp0_valid_d = 1'b1;
                        resp0_err_d   = 1'b1;
                        resp0_data_d  = 32'd0;
                    end
                end
            end
            ST_DRAIN: begin
                if (md_ready_i || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_err_q   <= 1'b0;
            resp1_err_q   <= 1'b0;
            resp0_data_q  <= 32'd0;
            resp1_data_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_err_q   <= resp0_err_d;
            resp1_err_q   <= resp1_err_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    assign resp0_valid_o = resp0_valid_q;
    assign resp1_valid_o = resp1_valid_q;
    assign resp0_err_o   = resp0_err_q;
    assign resp1_err_o   = resp1_err_q;
    assign resp0_data_o  = resp0_data_q;
    assign resp1_data_o  = resp1_data_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uriscv_muldiv_arb.sv
// tb/tb_uriscv_muldiv_arb.sv - directed bench for uriscv_muldiv_arb with a behavioural muldiv unit
module tb_uriscv_muldiv_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, flush0, md_stall, md_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_ra, req0_rb, req1_ra, req1_rb, md_result;
    logic        req0_accept, req1_accept, resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [31:0] resp0_data, resp1_data, md_ra, md_rb;
    logic        md_valid, busy;
    logic [7:0]  md_inst;

    always #5 clk = ~clk;

    uriscv_muldiv_arb dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_op_i(req0_op), .req0_ra_i(req0_ra), .req0_rb_i(req0_rb),
        .req0_accept_o(req0_accept), .resp0_valid_o(resp0_valid), .resp0_data_o(resp0_data),
        .resp0_err_o(resp0_err), .flush0_i(flush0),
        .req1_valid_i(req1_valid), .req1_op_i(req1_op), .req1_ra_i(req1_ra), .req1_rb_i(req1_rb),
        .req1_accept_o(req1_accept), .resp1_valid_o(resp1_valid), .resp1_data_o(resp1_data),
        .resp1_err_o(resp1_err),
        .md_valid_o(md_valid), .md_inst_o(md_inst), .md_ra_o(md_ra), .md_rb_o(md_rb),
        .md_stall_i(md_stall), .md_ready_i(md_ready), .md_result_i(md_result),
        .busy_o(busy)
    );

    // Behavioural muldiv unit: MUL* ready 2 cycles after issue, DIV/REM 34
    function automatic logic [31:0] mdl_calc(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (inst[0]) begin p = sa * sb; return p[31:0]; end
        if (inst[1]) begin p = sa * sb; return p[63:32]; end
        if (inst[2]) begin p = sa * ub; return p[63:32]; end
        if (inst[3]) begin p = ua * ub; return p[63:32]; end
        if (inst[4]) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
        end
        if (inst[5]) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        if (inst[6]) begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
        end
        if (inst[7]) return (b == 32'd0) ? a : a % b;
        return 32'd0;
    endfunction

    int          mdl_left;
    logic [31:0] mdl_res;
    logic        suppress_ready, stray_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_left <= 0;
            mdl_res  <= 32'd0;
        end else if (md_valid && !md_stall) begin
            mdl_left <= (md_inst[7:4] != 4'd0) ? 34 : 2;
            mdl_res  <= mdl_calc(md_inst, md_ra, md_rb);
        end else if (mdl_left > 0) begin
            mdl_left <= mdl_left - 1;
        end
    end

    assign md_ready  = ((mdl_left == 1) && !suppress_ready) || stray_ready;
    assign md_result = mdl_res;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-window event recorder, cycle numbers relative to clear_rec()
    int          rel, acc0, acc1, n_acc0, n_acc1, rsp0, rsp1, n_rsp0, n_rsp1;
    logic [31:0] d0, d1, ra_acc;
    logic        e0, e1, busy_rsp, auto_drop;
    logic [7:0]  inst_acc;
    int          gq_port[$];
    int          gq_cyc[$];

    task automatic clear_rec();
        rel = 0; acc0 = -1; acc1 = -1; n_acc0 = 0; n_acc1 = 0;
        rsp0 = -1; rsp1 = -1; n_rsp0 = 0; n_rsp1 = 0;
        d0 = 32'd0; d1 = 32'd0; e0 = 1'b0; e1 = 1'b0; busy_rsp = 1'b1;
        inst_acc = 8'd0; ra_acc = 32'd0;
        gq_port.delete(); gq_cyc.delete();
    endtask

    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        a0 = req0_accept;
        a1 = req1_accept;
        if (a0) begin acc0 = rel; n_acc0++; inst_acc = md_inst; ra_acc = md_ra; gq_port.push_back(0); gq_cyc.push_back(rel); end
        if (a1) begin acc1 = rel; n_acc1++; inst_acc = md_inst; ra_acc = md_ra; gq_port.push_back(1); gq_cyc.push_back(rel); end
        if (resp0_valid) begin rsp0 = rel; n_rsp0++; d0 = resp0_data; e0 = resp0_err; busy_rsp = busy; end
        if (resp1_valid) begin rsp1 = rel; n_rsp1++; d1 = resp1_data; e1 = resp1_err; busy_rsp = busy; end
        @(posedge clk);
        #1;
        if (auto_drop && a0) req0_valid = 1'b0;
        if (auto_drop && a1) req1_valid = 1'b0;
        rel++;
    endtask

    task automatic run_until_rsp(input int port, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if ((port == 0 && n_rsp0 > 0) || (port == 1 && n_rsp1 > 0)) break;
            cycle();
        end
    endtask

    task automatic set_req(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin req0_valid = 1'b1; req0_op = op; req0_ra = a; req0_rb = b; end
        else begin req1_valid = 1'b1; req1_op = op; req1_ra = a; req1_rb = b; end
    endtask

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [7:0]  inst;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 3'd0, 32'd7,          32'd6,          8'h01, 32'd42,         3};
        vecs[1] = '{1, 3'd1, 32'hFFFF_FFFF,  32'd2,          8'h02, 32'hFFFF_FFFF,  3};
        vecs[2] = '{0, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  8'h04, 32'hFFFF_FFFF,  3};
        vecs[3] = '{1, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  8'h08, 32'hFFFF_FFFE,  3};
        vecs[4] = '{0, 3'd4, 32'hFFFF_FFF6,  32'd3,          8'h10, 32'hFFFF_FFFD,  35};
        vecs[5] = '{1, 3'd5, 32'd100,        32'd7,          8'h20, 32'd14,         35};
        vecs[6] = '{0, 3'd6, 32'hFFFF_FFF6,  32'd3,          8'h40, 32'hFFFF_FFFF,  35};
        vecs[7] = '{1, 3'd7, 32'd100,        32'd7,          8'h80, 32'd2,          35};
        vecs[8] = '{0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  8'h10, 32'h8000_0000,  35};
        vecs[9] = '{1, 3'd7, 32'd5,          32'd0,          8'h80, 32'd5,          35};

        rst = 1'b1; flush0 = 1'b0; md_stall = 1'b0; suppress_ready = 1'b0; stray_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_ra = 32'd0; req0_rb = 32'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_ra = 32'd0; req1_rb = 32'd0;
        auto_drop = 1'b1;
        clear_rec();

        // Reset state, with a request present that must not be offered
        set_req(0, 3'd0, 32'd7, 32'd6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_md_valid", {31'd0, md_valid}, 32'd0);
        chk("rst_accept0", {31'd0, req0_accept}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_md_inst", {24'd0, md_inst}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp0_valid, resp1_valid}, 32'd0);
        chk("rst_resp_data", resp0_data | resp1_data, 32'd0);
        chk("rst_resp_err", {30'd0, resp0_err, resp1_err}, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Both ports in the same cycle: port 0 first, port 1 on the cycle its result returns
        set_req(0, 3'd5, 32'd100, 32'd7);
        set_req(1, 3'd7, 32'd100, 32'd7);
        clear_rec();
        for (int i = 0; i < 80 && n_rsp1 == 0; i++) cycle();
        chk("tie_acc0_cyc", acc0, 0);
        chk("tie_acc1_cyc", acc1, 35);
        chk("tie_rsp0_cyc", rsp0, 35);
        chk("tie_rsp0_data", d0, 32'd14);
        chk("tie_rsp1_cyc", rsp1, 70);
        chk("tie_rsp1_data", d1, 32'd2);

        // Persistent requests on both ports alternate
        auto_drop = 1'b0;
        set_req(0, 3'd0, 32'd2, 32'd3);
        set_req(1, 3'd0, 32'd4, 32'd5);
        clear_rec();
        for (int i = 0; i < 30 && gq_port.size() < 3; i++) cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        auto_drop = 1'b1;
        repeat (6) cycle();
        chk("rr_grants", gq_port.size(), 3);
        if (gq_port.size() == 3) begin
            chk("rr_g0_port", gq_port[0], 0);
            chk("rr_g1_port", gq_port[1], 1);
            chk("rr_g2_port", gq_port[2], 0);
            chk("rr_g1_cyc", gq_cyc[1], 3);
            chk("rr_g2_cyc", gq_cyc[2], 6);
        end

        // Table of single-port operations covering every funct3
        foreach (vecs[k]) begin
            set_req(vecs[k].port, vecs[k].op, vecs[k].ra, vecs[k].rb);
            clear_rec();
            run_until_rsp(vecs[k].port, 60);
            if (vecs[k].port == 0) begin
                chk($sformatf("v%0d_acc_cyc", k), acc0, 0);
                chk($sformatf("v%0d_rsp_cyc", k), rsp0, vecs[k].lat);
                chk($sformatf("v%0d_data", k), d0, vecs[k].res);
                chk($sformatf("v%0d_err", k), {31'd0, e0}, 32'd0);
                chk($sformatf("v%0d_other", k), n_rsp1, 0);
            end else begin
                chk($sformatf("v%0d_acc_cyc", k), acc1, 0);
                chk($sformatf("v%0d_rsp_cyc", k), rsp1, vecs[k].lat);
                chk($sformatf("v%0d_data", k), d1, vecs[k].res);
                chk($sformatf("v%0d_err", k), {31'd0, e1}, 32'd0);
                chk($sformatf("v%0d_other", k), n_rsp0, 0);
            end
            chk($sformatf("v%0d_inst", k), {24'd0, inst_acc}, {24'd0, vecs[k].inst});
            chk($sformatf("v%0d_ra", k), ra_acc, vecs[k].ra);
            chk($sformatf("v%0d_busy", k), {31'd0, busy_rsp}, 32'd0);
        end

        // Flush of a port 0 divide drains; port 1 waits for the unit to finish
        set_req(0, 3'd4, 32'hFFFF_FFF6, 32'd3);
        clear_rec();
        for (int c = 0; c < 45; c++) begin
            if (c == 5) set_req(1, 3'd1, 32'hFFFF_FFFF, 32'd2);
            flush0 = (c == 10);
            if (c == 20) chk("fl_busy_drain", {31'd0, busy}, 32'd1);
            cycle();
        end
        flush0 = 1'b0;
        chk("fl_acc0_cyc", acc0, 0);
        chk("fl_no_rsp0", n_rsp0, 0);
        chk("fl_acc1_cyc", acc1, 35);
        chk("fl_rsp1_cyc", rsp1, 38);
        chk("fl_rsp1_data", d1, 32'hFFFF_FFFF);

        // Flush coinciding with md_ready: result dropped, back to IDLE at once
        set_req(0, 3'd0, 32'd7, 32'd7);
        clear_rec();
        cycle();
        set_req(1, 3'd0, 32'd2, 32'd2);
        cycle();
        flush0 = 1'b1;
        cycle();
        flush0 = 1'b0;
        run_until_rsp(1, 20);
        chk("flr_no_rsp0", n_rsp0, 0);
        chk("flr_acc1_cyc", acc1, 3);
        chk("flr_rsp1_cyc", rsp1, 6);
        chk("flr_rsp1_data", d1, 32'd4);

        // Flush is ignored while port 1 owns the unit
        set_req(1, 3'd0, 32'd9, 32'd9);
        clear_rec();
        cycle();
        flush0 = 1'b1;
        cycle();
        flush0 = 1'b0;
        run_until_rsp(1, 20);
        chk("flo1_rsp1_cyc", rsp1, 3);
        chk("flo1_rsp1_data", d1, 32'd81);

        // Stall holds the offer without accepting
        md_stall = 1'b1;
        set_req(1, 3'd0, 32'd5, 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("st_md_valid", {31'd0, md_valid}, 32'd1);
            chk("st_no_accept", {31'd0, req1_accept}, 32'd0);
            chk("st_ra", md_ra, 32'd5);
            chk("st_inst", {24'd0, md_inst}, 32'h01);
            @(posedge clk); #1;
        end
        md_stall = 1'b0;
        clear_rec();
        run_until_rsp(1, 20);
        chk("st_acc1_cyc", acc1, 0);
        chk("st_rsp1_cyc", rsp1, 3);
        chk("st_rsp1_data", d1, 32'd25);

        // Spurious md_ready while IDLE is ignored
        stray_ready = 1'b1;
        clear_rec();
        cycle();
        stray_ready = 1'b0;
        repeat (2) cycle();
        chk("stray_no_rsp", n_rsp0 + n_rsp1, 0);
        chk("stray_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a divide
        set_req(0, 3'd4, 32'd1000, 32'd10);
        clear_rec();
        repeat (12) cycle();
        set_req(1, 3'd0, 32'd3, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_md_valid", {31'd0, md_valid}, 32'd0);
        chk("ar_accept", {30'd0, req0_accept, req1_accept}, 32'd0);
        chk("ar_resp_valid", {30'd0, resp0_valid, resp1_valid}, 32'd0);
        chk("ar_resp0_data", resp0_data, 32'd0);
        chk("ar_resp1_data", resp1_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 3'd0, 32'd7, 32'd6);
        clear_rec();
        for (int i = 0; i < 20 && n_rsp1 == 0; i++) cycle();
        chk("ar_post_acc0", acc0, 0);
        chk("ar_post_acc1", acc1, 3);
        chk("ar_post_rsp0", d0, 32'd42);
        chk("ar_post_rsp1_cyc", rsp1, 6);
        chk("ar_post_rsp1", d1, 32'd12);

`ifdef UMD_ARB_TIMEOUT_EN
        // Watchdog: unit never answers, owner gets an error response at cycle 40
        suppress_ready = 1'b1;
        set_req(1, 3'd0, 32'd3, 32'd3);
        clear_rec();
        run_until_rsp(1, 60);
        chk("to_rsp1_cyc", rsp1, 40);
        chk("to_rsp1_err", {31'd0, e1}, 32'd1);
        chk("to_rsp1_data", d1, 32'd0);
        repeat (3) cycle();
        suppress_ready = 1'b0;
        stray_ready = 1'b1;
        cycle();
        stray_ready = 1'b0;
        repeat (3) cycle();
        chk("to_late_ignored", n_rsp1, 1);
        chk("to_busy", {31'd0, busy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uriscv_muldiv_arb.md
Name: uriscv_muldiv_arb

Overview:
Two-port arbiter and sequencer that shares one multiply/divide unit between the core pipeline (port 0) and an auxiliary requester such as a coprocessor or debug engine (port 1). It arbitrates round-robin and decodes a 3-bit funct3 opcode into the unit's one-hot inst_* strobes. It keeps exactly one operation outstanding and routes the registered result back to the port that owns it. Port 0 can be flushed mid-operation; the late result is then drained and discarded.

Parameters:
TIMEOUT_CYCLES, 40, watchdog limit in cycles from issue to ready_i (used only when UMD_ARB_TIMEOUT_EN is defined); must be at least 36.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req0_valid_i  in  1  port 0 request; held with op/operands stable until accepted
req0_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req0_ra_i  in  32  operand A
req0_rb_i  in  32  operand B
req0_accept_o  out  1  one-cycle pulse: port 0 request issued
resp0_valid_o  out  1  one-cycle pulse: port 0 result valid
resp0_data_o  out  32  port 0 result
resp0_err_o  out  1  timeout flag, qualified by resp0_valid_o
flush0_i  in  1  discard port 0's outstanding operation
req1_valid_i, req1_op_i, req1_ra_i, req1_rb_i, req1_accept_o, resp1_valid_o, resp1_data_o, resp1_err_o: port 1, same widths and meanings as port 0; no flush
md_valid_o  out  1  issue strobe to the muldiv unit
md_inst_o  out  8  one-hot {remu, rem, divu, div, mulhu, mulhsu, mulh, mul}; bit n set for funct3 n
md_ra_o  out  32  operand A to the unit
md_rb_o  out  32  operand B to the unit
md_stall_i  in  1  unit stall
md_ready_i  in  1  unit result valid, one-cycle pulse
md_result_i  in  32  unit result
busy_o  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_i=1): state=IDLE, rr_ptr=0, owner=0, all *_accept_o/resp*_valid_o/resp*_err_o=0, resp*_data_o=0, md_valid_o=0. The muldiv unit must be reset in the same cycles.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE: winner chosen combinationally.
  - Only one port valid: that port wins.
  - Both valid: the port equal to rr_ptr wins.
  - md_valid_o=1 with the winner's decoded op and operands; md_inst_o=0 and md_valid_o=0 when no port is valid.
  - Issue when the winner is valid and md_stall_i=0: pulse the winner's accept combinationally in the same cycle, owner<=winner, rr_ptr<=~winner, state<=WAIT.
  - md_stall_i=1: no accept; re-arbitrate the next cycle.
- WAIT: md_valid_o=0, md_inst_o=0.
  - md_ready_i: capture md_result_i into the owner's resp_data register; owner's resp_valid pulses the next cycle; state<=IDLE.
  - A new issue is possible in the cycle after md_ready_i, i.e. the same cycle resp_valid is high.
- flush0_i in WAIT with owner=0 and no md_ready_i that cycle: state<=DRAIN. No resp0_valid is ever produced for that operation.
- flush0_i in the same cycle as md_ready_i: the flush wins; the result is discarded and state<=IDLE.
- flush0_i is ignored when owner=1 or state=IDLE.
- DRAIN: md_valid_o=0; wait for md_ready_i, discard the result, state<=IDLE.
- Latency with the team's muldiv unit (accept at cycle 0): MUL* ready_i at cycle 2, resp_valid at 3; DIV/REM ready_i at 34, resp_valid at 35.
- resp*_data_o holds its last value between pulses.
- Operands are passed unmodified; divide-by-zero and overflow semantics belong to the unit.
- md_ready_i while in IDLE is spurious: ignore it.

Optional Feature:
- Macro: UMD_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on issue and increments in WAIT/DRAIN.
  - Reaching TIMEOUT_CYCLES with no md_ready_i: in WAIT, the owner gets resp_valid=1, resp_err=1, resp_data=0; in DRAIN, silent return. State<=IDLE either way.
  - A later stray md_ready_i lands in IDLE and is ignored.
- Not defined: no counter; resp*_err_o tied 0; WAIT/DRAIN wait indefinitely.

Test Plan:
1. Port 0 MUL ra=7, rb=6 in IDLE -> req0_accept at cycle 0, md_inst_o=8'h01; resp0_valid at cycle 3 with data 42; busy_o low at cycle 3.
2. Both ports valid in the same cycle after reset: port0 DIVU 100/7, port1 REMU 100/7 -> port0 accepted first, resp0 data 14 at cycle 35; port1 accepted at cycle 35, resp1 data 2 at cycle 70; with persistent requests, grants alternate.
3. Port 0 DIV 0xFFFFFFF6/3 with flush0_i at cycle 10 -> DRAIN; no resp0_valid; the next port 1 MULH request is accepted only after md_ready_i (cycle 35).
4. md_stall_i forced high for 5 cycles with port 1 valid -> no accept, md_valid_o high, operands stable; accept on the first cycle stall drops.
5. rst_i asserted asynchronously mid-WAIT (cycle 12 of a DIV) -> all outputs 0 immediately, state IDLE, rr_ptr=0; a post-reset MUL from port 1 completes normally.
6. (UMD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=40) md_ready_i suppressed after a port 1 issue -> resp1_valid=1, resp1_err=1, resp1_data=0 at cycle 40; a late md_ready_i is ignored.
